// File: rtl/norm_pkg.sv
// Shared types and default sizes for the normalizer scheduler.
package norm_pkg;
  localparam int BW_PSUM_DEF = 16;
  localparam int COL_DEF     = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALF  = 3'd1,
    S_WAKE  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_HOLD  = 3'd5
  } state_t;
endpackage

// File: rtl/norm_stage.sv
// One requester's valid/ready staging register; holds the vector until the run retires.
module norm_stage
  import norm_pkg::*;
#(
  parameter int W = BW_PSUM_DEF * COL_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic         i_en,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_acc,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_ready;

  // ready is qualified by reset so every output reads 0 while reset is held
  assign w_ready = reset & i_en & ~r_full;
  assign o_ready = w_ready;
  assign o_acc   = i_valid & w_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (o_acc) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end
endmodule

// File: rtl/norm_scheduler.sv
// Pairs one psum vector from each requester and sequences a gated normalizer run per pair.
//   state | meaning
//   IDLE  | both sides ready, waiting for vectors
//   HALF  | one side staged, waiting for the other
//   WAKE  | gate raised one cycle ahead of s_valid
//   ISSUE | single s_valid pulse to both normalizer inputs
//   DRAIN | counting output beats, bounded by TIMEOUT
//   HOLD  | gate held GATE_HOLD cycles before sleeping
module norm_scheduler
  import norm_pkg::*;
#(
  parameter int BW_PSUM   = BW_PSUM_DEF,
  parameter int COL       = COL_DEF,
  parameter int GATE_HOLD = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid_1,
  output logic                   req_ready_1,
  input  logic [COL*BW_PSUM-1:0] req_psum_1,
  input  logic                   req_valid_2,
  output logic                   req_ready_2,
  input  logic [COL*BW_PSUM-1:0] req_psum_2,
  output logic                   norm_s_valid_1,
  output logic                   norm_s_valid_2,
  output logic [COL*BW_PSUM-1:0] norm_psum_1,
  output logic [COL*BW_PSUM-1:0] norm_psum_2,
  input  logic                   norm_valid,
  output logic                   norm_gate,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       pair_count,
  output logic                   err_timeout,
  output logic                   err_spurious
);
  localparam int VW  = COL * BW_PSUM;
  localparam int BCW = $clog2(COL + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int HCW = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;

  state_t           r_state;
  logic [BCW-1:0]   r_beat;
  logic [TCW-1:0]   r_to;
  logic [HCW-1:0]   r_hold;
  logic             r_gate, r_s_valid, r_done, r_err_to, r_err_spur;
  logic [CNT_W-1:0] r_pairs;
  logic             w_stage_en, w_clear, w_acc_1, w_acc_2, w_full_1, w_full_2;

  assign w_stage_en = (r_state == S_IDLE) || (r_state == S_HALF);
  assign w_clear    = (r_state == S_HOLD) && (r_hold == '0);

  norm_stage #(.W(VW)) u_stage_1 (
    .clk(clk), .reset(reset), .i_valid(req_valid_1), .i_en(w_stage_en), .i_clear(w_clear),
    .i_data(req_psum_1), .o_ready(req_ready_1), .o_acc(w_acc_1), .o_full(w_full_1),
    .o_data(norm_psum_1)
  );

  norm_stage #(.W(VW)) u_stage_2 (
    .clk(clk), .reset(reset), .i_valid(req_valid_2), .i_en(w_stage_en), .i_clear(w_clear),
    .i_data(req_psum_2), .o_ready(req_ready_2), .o_acc(w_acc_2), .o_full(w_full_2),
    .o_data(norm_psum_2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_to       <= '0;
      r_hold     <= '0;
      r_gate     <= 1'b0;
      r_s_valid  <= 1'b0;
      r_done     <= 1'b0;
      r_pairs    <= '0;
      r_err_to   <= 1'b0;
      r_err_spur <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_s_valid <= 1'b0;
      if (norm_valid && (r_state != S_DRAIN)) r_err_spur <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_acc_1 && w_acc_2) begin
            r_state <= S_WAKE;
            r_gate  <= 1'b1;
          end else if (w_acc_1 || w_acc_2) begin
            r_state <= S_HALF;
          end
        end
        S_HALF: begin
          if (w_acc_1 || w_acc_2) begin
            r_state <= S_WAKE;
            r_gate  <= 1'b1;
          end
        end
        S_WAKE: begin
          r_state   <= S_ISSUE;
          r_s_valid <= 1'b1;
        end
        S_ISSUE: begin
          r_state <= S_DRAIN;
          r_beat  <= '0;
          r_to    <= '0;
        end
        S_DRAIN: begin
          // a final beat landing on the timeout cycle still counts as a completed run
          if (norm_valid && (r_beat == BCW'(COL - 1))) begin
            r_state <= S_HOLD;
            r_done  <= 1'b1;
            r_pairs <= r_pairs + 1'b1;
            r_hold  <= HCW'(GATE_HOLD - 1);
          end else if (r_to == TCW'(TIMEOUT - 1)) begin
            r_state  <= S_HOLD;
            r_err_to <= 1'b1;
            r_hold   <= HCW'(GATE_HOLD - 1);
          end else begin
            r_beat <= r_beat + BCW'(norm_valid);
            r_to   <= r_to + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_hold == '0) begin
            r_state <= S_IDLE;
            r_gate  <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign norm_s_valid_1 = r_s_valid;
  assign norm_s_valid_2 = r_s_valid;
  assign norm_gate      = r_gate;
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign pair_count     = r_pairs;
  assign err_timeout    = r_err_to;
  assign err_spurious   = r_err_spur;
endmodule

// File: tb/tb_norm_scheduler.sv
// Directed bench for norm_scheduler with TIMEOUT=20 and CNT_W=4.
module tb_norm_scheduler;
  localparam int BW = 16;
  localparam int COL = 8;
  localparam int VW = BW * COL;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid_1 = 1'b0, req_valid_2 = 1'b0, norm_valid = 1'b0;
  logic [VW-1:0] req_psum_1 = '0, req_psum_2 = '0;
  logic          req_ready_1, req_ready_2, norm_s_valid_1, norm_s_valid_2;
  logic [VW-1:0] norm_psum_1, norm_psum_2;
  logic          norm_gate, busy, done, err_timeout, err_spurious;
  logic [CW-1:0] pair_count;

  int total = 0;
  int bad = 0;

  norm_scheduler #(
    .BW_PSUM(BW), .COL(COL), .GATE_HOLD(2), .TIMEOUT(20), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_psum_1(req_psum_1),
    .req_valid_2(req_valid_2), .req_ready_2(req_ready_2), .req_psum_2(req_psum_2),
    .norm_s_valid_1(norm_s_valid_1), .norm_s_valid_2(norm_s_valid_2),
    .norm_psum_1(norm_psum_1), .norm_psum_2(norm_psum_2),
    .norm_valid(norm_valid), .norm_gate(norm_gate), .busy(busy), .done(done),
    .pair_count(pair_count), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mkvec(input int base, input int mul);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = BW'(base + mul * i);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid_1 = 1'b0; req_valid_2 = 1'b0; norm_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Presents both vectors in one cycle and returns at the first DRAIN negedge.
  task automatic drive_pair(input logic [VW-1:0] a, input logic [VW-1:0] b);
    req_valid_1 = 1'b1; req_valid_2 = 1'b1; req_psum_1 = a; req_psum_2 = b;
    @(negedge clk);
    req_valid_1 = 1'b0; req_valid_2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if ({req_ready_1, req_ready_2, norm_s_valid_1, norm_s_valid_2, norm_gate, busy, done,
         err_timeout, err_spurious, pair_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got r1=%b r2=%b sv=%b%b gate=%b busy=%b done=%b to=%b sp=%b pc=%0d want all 0",
               req_ready_1, req_ready_2, norm_s_valid_1, norm_s_valid_2, norm_gate, busy, done,
               err_timeout, err_spurious, pair_count);
    end
    total++;
    if ({norm_psum_1, norm_psum_2} !== '0) begin
      bad++;
      $display("FAIL reset_psum: got %h %h want 0", norm_psum_1, norm_psum_2);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_same_edge();
    logic [VW-1:0] a, b;
    a = mkvec(0, 1);
    b = mkvec(0, 2);
    req_valid_1 = 1'b1; req_valid_2 = 1'b1; req_psum_1 = a; req_psum_2 = b;
    total++;
    if ({req_ready_1, req_ready_2, busy} !== 3'b110) begin
      bad++;
      $display("FAIL idle_ready: got r1=%b r2=%b busy=%b want 1 1 0", req_ready_1, req_ready_2, busy);
    end
    @(negedge clk);
    req_valid_1 = 1'b0; req_valid_2 = 1'b0;
    total++;
    if ({norm_gate, norm_s_valid_1, busy, req_ready_1, req_ready_2} !== 5'b10100) begin
      bad++;
      $display("FAIL wake: got gate=%b sv=%b busy=%b r=%b%b want 1 0 1 00",
               norm_gate, norm_s_valid_1, busy, req_ready_1, req_ready_2);
    end
    @(negedge clk);
    total++;
    if ({norm_s_valid_1, norm_s_valid_2, norm_gate} !== 3'b111) begin
      bad++;
      $display("FAIL issue_pulse: got sv=%b%b gate=%b want 11 1", norm_s_valid_1, norm_s_valid_2, norm_gate);
    end
    total++;
    if (norm_psum_1 !== a || norm_psum_2 !== b) begin
      bad++;
      $display("FAIL issue_psum: got %h %h want %h %h", norm_psum_1, norm_psum_2, a, b);
    end
    @(negedge clk);
    total++;
    if ({norm_s_valid_1, norm_s_valid_2} !== 2'b00) begin
      bad++;
      $display("FAIL pulse_width: got sv=%b%b want 00", norm_s_valid_1, norm_s_valid_2);
    end
    for (int i = 0; i < COL; i++) begin
      norm_valid = 1'b1;
      @(negedge clk);
      total++;
      if (done !== (i == COL - 1)) begin
        bad++;
        $display("FAIL beat_done: beat %0d got done=%b want %b", i, done, (i == COL - 1));
      end
    end
    norm_valid = 1'b0;
    total++;
    if (pair_count !== 4'd1 || norm_psum_2 !== b) begin
      bad++;
      $display("FAIL run1_count: got pc=%0d psum2=%h want 1 %h", pair_count, norm_psum_2, b);
    end
    @(negedge clk);
    total++;
    if ({norm_gate, busy, done} !== 3'b110) begin
      bad++;
      $display("FAIL hold2: got gate=%b busy=%b done=%b want 1 1 0", norm_gate, busy, done);
    end
    @(negedge clk);
    total++;
    if ({norm_gate, busy, err_spurious, err_timeout} !== 4'b0000) begin
      bad++;
      $display("FAIL back_idle: got gate=%b busy=%b sp=%b to=%b want 0000", norm_gate, busy, err_spurious, err_timeout);
    end
  endtask

  task automatic test_half();
    logic [VW-1:0] a, b;
    a = mkvec(16'h1100, 3);
    b = mkvec(16'hA000, 1);
    req_valid_2 = 1'b1; req_psum_2 = b;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      req_psum_2 = mkvec(16'h5500 + c, 7);
      total++;
      if ({req_ready_2, req_ready_1, busy, norm_gate} !== 4'b0110) begin
        bad++;
        $display("FAIL half_ready: cycle %0d got r2=%b r1=%b busy=%b gate=%b want 0 1 1 0",
                 c, req_ready_2, req_ready_1, busy, norm_gate);
      end
      if (c == 5) begin
        req_valid_1 = 1'b1; req_psum_1 = a;
      end
      @(negedge clk);
    end
    req_valid_1 = 1'b0;
    total++;
    if ({norm_gate, norm_s_valid_1} !== 2'b10) begin
      bad++;
      $display("FAIL half_wake: got gate=%b sv=%b want 1 0", norm_gate, norm_s_valid_1);
    end
    @(negedge clk);
    total++;
    if (norm_s_valid_2 !== 1'b1 || norm_psum_2 !== b || norm_psum_1 !== a) begin
      bad++;
      $display("FAIL half_issue: got sv=%b p1=%h p2=%h want 1 %h %h", norm_s_valid_2, norm_psum_1, norm_psum_2, a, b);
    end
    req_valid_2 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < COL; i++) begin
      norm_valid = 1'b1;
      @(negedge clk);
    end
    norm_valid = 1'b0;
    total++;
    if (done !== 1'b1 || pair_count !== 4'd2) begin
      bad++;
      $display("FAIL half_done: got done=%b pc=%0d want 1 2", done, pair_count);
    end
    repeat (4) @(negedge clk);
    total++;
    if ({busy, norm_gate, norm_s_valid_1} !== 3'b000) begin
      bad++;
      $display("FAIL half_single_run: got busy=%b gate=%b sv=%b want 000", busy, norm_gate, norm_s_valid_1);
    end
  endtask

  task automatic test_timeout();
    drive_pair(mkvec(1, 1), mkvec(2, 2));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      total++;
      if (err_timeout !== (k == 20) || done !== 1'b0) begin
        bad++;
        $display("FAIL timeout_at: drain cycle %0d got to=%b done=%b want %b 0", k, err_timeout, done, (k == 20));
      end
    end
    @(negedge clk);
    total++;
    if ({norm_gate, busy, done} !== 3'b110) begin
      bad++;
      $display("FAIL timeout_hold: got gate=%b busy=%b done=%b want 1 1 0", norm_gate, busy, done);
    end
    @(negedge clk);
    total++;
    if ({norm_gate, busy, err_timeout} !== 3'b001 || pair_count !== 4'd2) begin
      bad++;
      $display("FAIL timeout_idle: got gate=%b busy=%b to=%b pc=%0d want 0 0 1 2",
               norm_gate, busy, err_timeout, pair_count);
    end
  endtask

  task automatic test_spurious();
    total++;
    if (err_spurious !== 1'b0) begin
      bad++;
      $display("FAIL spur_before: got %b want 0", err_spurious);
    end
    norm_valid = 1'b1;
    @(negedge clk);
    norm_valid = 1'b0;
    total++;
    if ({err_spurious, busy, norm_gate} !== 3'b100) begin
      bad++;
      $display("FAIL spur_idle: got sp=%b busy=%b gate=%b want 1 0 0", err_spurious, busy, norm_gate);
    end
    drive_pair(mkvec(3, 5), mkvec(4, 6));
    for (int i = 0; i < COL; i++) begin
      norm_valid = 1'b1;
      @(negedge clk);
      total++;
      if (done !== (i == COL - 1)) begin
        bad++;
        $display("FAIL spur_beats: beat %0d got done=%b want %b", i, done, (i == COL - 1));
      end
    end
    norm_valid = 1'b0;
    total++;
    if (pair_count !== 4'd3) begin
      bad++;
      $display("FAIL spur_count: got %0d want 3", pair_count);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] a, b;
    a = mkvec(16'h0700, 9);
    b = mkvec(16'h0800, 4);
    drive_pair(mkvec(16'h0300, 1), mkvec(16'h0400, 1));
    for (int i = 0; i < 4; i++) begin
      norm_valid = 1'b1;
      @(negedge clk);
    end
    norm_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if ({norm_gate, busy, done, norm_s_valid_1, req_ready_1, req_ready_2, err_timeout, err_spurious,
         pair_count} !== '0 || {norm_psum_1, norm_psum_2} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got gate=%b busy=%b done=%b sv=%b r=%b%b to=%b sp=%b pc=%0d want all 0",
               norm_gate, busy, done, norm_s_valid_1, req_ready_1, req_ready_2, err_timeout,
               err_spurious, pair_count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive_pair(a, b);
    total++;
    if (norm_psum_1 !== a || norm_psum_2 !== b) begin
      bad++;
      $display("FAIL mid_rerun_psum: got %h %h want %h %h", norm_psum_1, norm_psum_2, a, b);
    end
    for (int i = 0; i < COL; i++) begin
      norm_valid = 1'b1;
      @(negedge clk);
    end
    norm_valid = 1'b0;
    total++;
    if (done !== 1'b1 || pair_count !== 4'd1 || err_spurious !== 1'b0) begin
      bad++;
      $display("FAIL mid_rerun: got done=%b pc=%0d sp=%b want 1 1 0", done, pair_count, err_spurious);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int p = 0; p < 17; p++) begin
      drive_pair(mkvec(p, 1), mkvec(p, 3));
      for (int i = 0; i < COL; i++) begin
        norm_valid = 1'b1;
        @(negedge clk);
      end
      norm_valid = 1'b0;
      total++;
      if (done !== 1'b1 || pair_count !== CW'((p + 1) % 16)) begin
        bad++;
        $display("FAIL b2b_count: pair %0d got done=%b pc=%0d want 1 %0d", p, done, pair_count, (p + 1) % 16);
      end
      repeat (2) @(negedge clk);
      total++;
      if (norm_gate !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_gap: pair %0d got gate=%b busy=%b want 0 0", p, norm_gate, busy);
      end
    end
    total++;
    if (pair_count !== 4'd1) begin
      bad++;
      $display("FAIL b2b_wrap: got %0d want 1", pair_count);
    end
  endtask

  initial begin
    test_reset();
    test_same_edge();
    test_half();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
